// File: rtl/ram_emu_arbiter_if.sv
// Bus bundle between the two RAM-emulator requesters, the arbiter and the link serializer.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; the
// requester holds valid and its fields stable until it sees ready, and ready never waits on
// a later valid. Response pulses (rdataN_valid, wdone1) cannot be back-pressured.
interface ram_emu_arbiter_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 16
);
  logic                 req0_valid;
  logic [ADDR_BITS-1:0] req0_addr;
  logic                 req0_ready;

  logic                 req1_valid;
  logic                 req1_write;
  logic [ADDR_BITS-1:0] req1_addr;
  logic [DATA_BITS-1:0] req1_wdata;
  logic                 req1_ready;

  logic [DATA_BITS-1:0] rdata;
  logic                 rdata0_valid;
  logic                 rdata1_valid;
  logic                 wdone1;

  logic                 link_valid;
  logic                 link_ready;
  logic                 link_write;
  logic [ADDR_BITS-1:0] link_addr;
  logic [DATA_BITS-1:0] link_wdata;
  logic                 link_rdata_valid;
  logic [DATA_BITS-1:0] link_rdata;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr,
    output req0_ready,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready,
    output rdata, rdata0_valid, rdata1_valid, wdone1,
    output link_valid, link_write, link_addr, link_wdata,
    input  link_ready, link_rdata_valid, link_rdata
  );

  // Requesters plus link serializer side.
  modport master (
    output req0_valid, req0_addr,
    input  req0_ready,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready,
    input  rdata, rdata0_valid, rdata1_valid, wdone1,
    input  link_valid, link_write, link_addr, link_wdata,
    output link_ready, link_rdata_valid, link_rdata
  );
endinterface

// File: rtl/ram_emu_arbiter.sv
// Two-port arbiter in front of the RAM-emulator link: port 0 (video, read-only) has priority,
// port 1 (compute, read/write) is forced through after MAX_WAIT consecutive losses.
module ram_emu_arbiter #(
  parameter int          ADDR_BITS = 16,
  parameter int          DATA_BITS = 16,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  ram_emu_arbiter_if.slave  bus,
  output logic [1:0]        dbg_state,
  output logic [7:0]        dbg_starve_cnt
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           starve_q, starve_d;
  logic                 cmd_write_q, cmd_write_d;
  logic [ADDR_BITS-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_BITS-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                 owner_q, owner_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 rdata0_valid_q, rdata0_valid_d;
  logic                 rdata1_valid_q, rdata1_valid_d;
  logic                 wdone1_q, wdone1_d;

  logic idle;
  logic force1;
  logic grant0;
  logic grant1;

  // Grants are suppressed while reset is asserted so no requester sees a phantom accept.
  always_comb begin
    idle   = (state_q == ST_IDLE) && !reset;
    force1 = bus.req1_valid && (starve_q == MAX_WAIT_C);
    grant1 = idle && bus.req1_valid && (force1 || !bus.req0_valid);
    grant0 = idle && bus.req0_valid && !force1;
  end

  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    cmd_write_d    = cmd_write_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_wdata_d    = cmd_wdata_q;
    owner_d        = owner_q;
    rdata_d        = rdata_q;
    rdata0_valid_d = 1'b0;
    rdata1_valid_d = 1'b0;
    wdone1_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant0) begin
          state_d     = ST_ISSUE;
          cmd_write_d = 1'b0;
          cmd_addr_d  = bus.req0_addr;
          cmd_wdata_d = '0;
          owner_d     = 1'b0;
          // Only losses that port 1 actually suffered count toward forcing it through.
          if (bus.req1_valid && (starve_q != MAX_WAIT_C)) begin
            starve_d = starve_q + 8'd1;
          end
        end else if (grant1) begin
          state_d     = ST_ISSUE;
          cmd_write_d = bus.req1_write;
          cmd_addr_d  = bus.req1_addr;
          cmd_wdata_d = bus.req1_wdata;
          owner_d     = 1'b1;
          starve_d    = 8'd0;
        end
      end

      ST_ISSUE: begin
        if (bus.link_ready) begin
          if (cmd_write_q) begin
            state_d  = ST_IDLE;
            wdone1_d = 1'b1;
          end else begin
            state_d = ST_WAIT_RD;
          end
        end
      end

      ST_WAIT_RD: begin
        if (bus.link_rdata_valid) begin
          state_d        = ST_IDLE;
          rdata_d        = bus.link_rdata;
          rdata0_valid_d = !owner_q;
          rdata1_valid_d = owner_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      starve_q       <= 8'd0;
      cmd_write_q    <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_wdata_q    <= '0;
      owner_q        <= 1'b0;
      rdata_q        <= '0;
      rdata0_valid_q <= 1'b0;
      rdata1_valid_q <= 1'b0;
      wdone1_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      cmd_write_q    <= cmd_write_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_wdata_q    <= cmd_wdata_d;
      owner_q        <= owner_d;
      rdata_q        <= rdata_d;
      rdata0_valid_q <= rdata0_valid_d;
      rdata1_valid_q <= rdata1_valid_d;
      wdone1_q       <= wdone1_d;
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.link_valid   = (state_q == ST_ISSUE);
  assign bus.link_write   = cmd_write_q;
  assign bus.link_addr    = cmd_addr_q;
  assign bus.link_wdata   = cmd_wdata_q;
  assign bus.rdata        = rdata_q;
  assign bus.rdata0_valid = rdata0_valid_q;
  assign bus.rdata1_valid = rdata1_valid_q;
  assign bus.wdone1       = wdone1_q;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_ram_emu_arbiter.sv
// Bench for ram_emu_arbiter: directed scenarios then random traffic, all checked every cycle
// against a transaction-level model with its own memory image and an expected-read queue.
module tb_ram_emu_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_emu_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();
  logic [1:0] dbg_state;
  logic [7:0] dbg_starve_cnt;

  ram_emu_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .MAX_WAIT(MW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] link_mem  [logic [AW-1:0]];
  logic [DW-1:0] exp_q[$];

  bit            m_busy, m_sent, m_write, m_owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_starve;
  logic [DW-1:0] m_rdata;
  bit            m_rv0, m_rv1, m_wdone;

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] link_rd(input logic [AW-1:0] a);
    return link_mem.exists(a) ? link_mem[a] : '0;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    model_mem[a] = d;
    link_mem[a]  = d;
  endtask

  task automatic model_clear();
    m_busy = 0; m_sent = 0; m_write = 0; m_owner = 0;
    m_starve = 0; m_rdata = '0;
    m_rv0 = 0; m_rv1 = 0; m_wdone = 0;
    exp_q.delete();
  endtask

  // Which port the priority rule admits this cycle, given the current requests.
  task automatic exp_ready(output bit r0, output bit r1);
    r0 = 0;
    r1 = 0;
    if (!reset && !m_busy) begin
      if (bus.req1_valid && m_starve >= MW) r1 = 1;
      else if (bus.req0_valid)              r0 = 1;
      else if (bus.req1_valid)              r1 = 1;
    end
  endtask

  // One transaction moves forward per clock edge.
  task automatic model_step(input bit r0, input bit r1);
    m_rv0 = 0; m_rv1 = 0; m_wdone = 0;
    if (reset) begin
      model_clear();
    end else if (!m_busy) begin
      if (r0) begin
        m_busy = 1; m_sent = 0; m_write = 0; m_owner = 0;
        m_addr = bus.req0_addr;
        exp_q.push_back(model_rd(bus.req0_addr));
        if (bus.req1_valid && m_starve < MW) m_starve++;
      end else if (r1) begin
        m_busy = 1; m_sent = 0; m_write = bus.req1_write; m_owner = 1;
        m_addr = bus.req1_addr; m_wdata = bus.req1_wdata;
        if (!bus.req1_write) exp_q.push_back(model_rd(bus.req1_addr));
        m_starve = 0;
      end
    end else if (!m_sent) begin
      if (bus.link_ready) begin
        if (m_write) begin
          model_mem[m_addr] = m_wdata;
          m_busy = 0;
          m_wdone = 1;
        end else begin
          m_sent = 1;
        end
      end
    end else if (bus.link_rdata_valid) begin
      check("exp_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
      if (m_owner) m_rv1 = 1; else m_rv0 = 1;
      m_busy = 0;
      m_sent = 0;
    end
  endtask

  // ---------------- link emulation + per-cycle driver ----------------
  bit            rsp_pending;
  int            rsp_delay;
  logic [AW-1:0] rsp_addr;
  int            lat_cfg;
  bit            inj_valid;
  logic [DW-1:0] inj_data;
  bit            saw_r0, saw_r1, saw_lv, saw_rv0, saw_rv1, saw_wd;
  logic [DW-1:0] cap_rdata;

  // Called at posedge+1 with request inputs already set; returns at the next posedge+1.
  task automatic cycle();
    bit r0, r1;
    if (rsp_pending && rsp_delay == 0) begin
      bus.link_rdata_valid = 1'b1;
      bus.link_rdata       = link_rd(rsp_addr);
      rsp_pending          = 0;
    end else begin
      if (rsp_pending) rsp_delay--;
      bus.link_rdata_valid = inj_valid;
      bus.link_rdata       = inj_valid ? inj_data : DW'($urandom);
    end
    inj_valid = 0;
    #1;
    exp_ready(r0, r1);
    check("req0_ready", bus.req0_ready, r0);
    check("req1_ready", bus.req1_ready, r1);
    check("link_valid", bus.link_valid, m_busy && !m_sent);
    if (m_busy && !m_sent) begin
      check("link_write", bus.link_write, m_write);
      check("link_addr", bus.link_addr, m_addr);
      if (m_write) check("link_wdata", bus.link_wdata, m_wdata);
    end
    check("rdata0_valid", bus.rdata0_valid, m_rv0);
    check("rdata1_valid", bus.rdata1_valid, m_rv1);
    check("wdone1", bus.wdone1, m_wdone);
    check("rdata", bus.rdata, m_rdata);
    check("starve_cnt", dbg_starve_cnt, m_starve);
    saw_r0 = bus.req0_ready;     saw_r1 = bus.req1_ready;
    saw_lv = bus.link_valid;     saw_wd = bus.wdone1;
    saw_rv0 = bus.rdata0_valid;  saw_rv1 = bus.rdata1_valid;
    cap_rdata = bus.rdata;
    if (reset) begin
      rsp_pending = 0;
    end else if (bus.link_valid && bus.link_ready) begin
      if (bus.link_write) begin
        link_mem[bus.link_addr] = bus.link_wdata;
      end else begin
        rsp_pending = 1;
        rsp_addr    = bus.link_addr;
        rsp_delay   = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end
    end
    @(posedge clk);
    model_step(r0, r1);
    cyc++;
    #1;
  endtask

  task automatic await_ready(input bit port, output int at_cyc);
    bit hit;
    hit = 0;
    at_cyc = -1;
    for (int n = 0; n < 60 && !hit; n++) begin
      at_cyc = cyc;
      cycle();
      hit = port ? saw_r1 : saw_r0;
    end
    check(port ? "grant1_seen" : "grant0_seen", hit, 1);
  endtask

  task automatic await_rsp(input bit port, output int at_cyc);
    bit hit;
    hit = 0;
    at_cyc = -1;
    for (int n = 0; n < 60 && !hit; n++) begin
      at_cyc = cyc;
      cycle();
      hit = port ? saw_rv1 : saw_rv0;
    end
    check(port ? "rsp1_seen" : "rsp0_seen", hit, 1);
  endtask

  task automatic drain();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.link_ready = 1;
    for (int n = 0; n < 60 && (m_busy || rsp_pending); n++) cycle();
    cycle();
    check("drained_idle", m_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int g, r, n_lv, wd_at, n_pulse;
    int gseq[$];
    int gcyc[$];
    int exp_seq[8];
    exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};

    reset = 1;
    bus.req0_valid = 0; bus.req0_addr = '0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
    bus.link_ready = 0; bus.link_rdata_valid = 0; bus.link_rdata = '0;
    rsp_pending = 0; rsp_delay = 0; lat_cfg = 0; inj_valid = 0; inj_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    check("reset_state", dbg_state, 0);
    reset = 0;

    // Single port 0 read, data returned three cycles after issue.
    preload(16'h1234, 16'hBEEF);
    lat_cfg = 2;
    bus.link_ready = 1;
    bus.req0_valid = 1;
    bus.req0_addr  = 16'h1234;
    await_ready(0, g);
    bus.req0_valid = 0;
    await_rsp(0, r);
    check("t1_latency", r - g, 5);
    check("t1_rdata", cap_rdata, 16'hBEEF);
    check("t1_owner1", saw_rv1, 0);

    // Port 1 write with two cycles of link back-pressure.
    bus.link_ready = 0;
    bus.req1_valid = 1; bus.req1_write = 1;
    bus.req1_addr = 16'h0042; bus.req1_wdata = 16'hA5A5;
    await_ready(1, g);
    bus.req1_valid = 0;
    n_lv = 0; wd_at = -1;
    for (int k = 0; k < 5; k++) begin
      bus.link_ready = (k >= 2);
      cycle();
      n_lv += int'(saw_lv);
      if (saw_wd) wd_at = k;
    end
    check("t2_link_valid_cycles", n_lv, 3);
    check("t2_wdone_cycle", wd_at, 3);
    check("t2_link_mem", link_rd(16'h0042), 16'hA5A5);

    // Contention: both ports continuously reading, latency 1.
    lat_cfg = 1;
    bus.link_ready = 1;
    bus.req0_valid = 1; bus.req0_addr = AW'($urandom_range(0, 15));
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = AW'($urandom_range(0, 15));
    for (int n = 0; n < 200 && gseq.size() < 8; n++) begin
      cycle();
      if (saw_r0) begin
        gseq.push_back(0);
        bus.req0_addr = AW'($urandom_range(0, 15));
      end
      if (saw_r1) begin
        gseq.push_back(1);
        bus.req1_addr = AW'($urandom_range(0, 15));
        check("t3_starve_clear", dbg_starve_cnt, 0);
      end
    end
    check("t3_grant_count", gseq.size(), 8);
    for (int k = 0; k < 8 && k < gseq.size(); k++) check($sformatf("t3_grant_%0d", k), gseq[k], exp_seq[k]);
    drain();

    // Spurious response while idle.
    inj_valid = 1;
    inj_data  = 16'hFFFF;
    n_pulse = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_pulse += int'(saw_rv0) + int'(saw_rv1);
    end
    check("t4_no_pulse", n_pulse, 0);
    check("t4_rdata_hold", cap_rdata, m_rdata);

    // Reset while a port 1 read waits for data, then the late data arrives.
    lat_cfg = 30;
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 16'h0042;
    await_ready(1, g);
    bus.req1_valid = 0;
    cycle();
    check("t5_in_wait", dbg_state, 2);
    reset = 1;
    cycle();
    reset = 0;
    inj_valid = 1;
    inj_data  = 16'h5A5A;
    n_pulse = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_pulse += int'(saw_rv0) + int'(saw_rv1) + int'(saw_wd) + int'(saw_lv);
    end
    check("t5_no_late_pulse", n_pulse, 0);
    lat_cfg = 1;
    bus.req1_valid = 1; bus.req1_addr = 16'h0042;
    await_ready(1, g);
    bus.req1_valid = 0;
    await_rsp(1, r);
    check("t5_rdata", cap_rdata, 16'hA5A5);

    // Back-to-back port 0 reads with zero link latency.
    for (int k = 0; k < 4; k++) preload(AW'(16'h0100 + k), DW'(16'hC000 + k));
    lat_cfg = 0;
    bus.req0_valid = 1;
    bus.req0_addr  = 16'h0100;
    for (int n = 0; n < 60 && gcyc.size() < 4; n++) begin
      g = cyc;
      cycle();
      if (saw_r0) begin
        gcyc.push_back(g);
        bus.req0_addr = AW'(16'h0100 + gcyc.size());
      end
    end
    bus.req0_valid = 0;
    check("t6_grant_count", gcyc.size(), 4);
    for (int k = 1; k < gcyc.size(); k++) check($sformatf("t6_spacing_%0d", k), gcyc[k] - gcyc[k-1], 3);
    drain();

    // Random traffic.
    lat_cfg = -1;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!bus.req0_valid || saw_r0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_addr  = AW'($urandom_range(0, 15));
      end
      if (!bus.req1_valid || saw_r1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_write = ($urandom_range(0, 1) != 0);
        bus.req1_addr  = AW'($urandom_range(0, 15));
        bus.req1_wdata = DW'($urandom);
      end
      bus.link_ready = ($urandom_range(0, 3) != 0);
      if (!rsp_pending && $urandom_range(0, 9) == 0) begin
        inj_valid = 1;
        inj_data  = DW'($urandom);
      end
      cycle();
    end
    reset = 0;
    drain();
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
